cpmg_seq_ctrl: RTL and testbench
================================

Name: cpmg_seq_ctrl

Overview:
- Sequences one CPMG NMR scan from the HPS-written timing registers (init_delay, pulse_90deg, delay_nosig, pulse_180deg, rx_delay, samples_per_echo, delay_sig, echoes_per_scan).
- Drives the TX gate/phase and the receive window.
- Streams ADC samples into the ADC FIFO sink (adc_fifo_in_data/valid/ready) only inside acquisition windows.
- Sits between the PIO export registers, the RF front end and the ADC FIFO.

Parameters:
- CNT_W, 32, width of all timing/count inputs
- ADC_W, 16, ADC sample and FIFO data width

Ports:
- clk_clk  in  1  system clock; all logic on rising edge
- reset_reset_n  in  1  asynchronous active-low reset
- start  in  1  scan request, sampled in IDLE only
- abort  in  1  synchronous abort, any state
- init_delay, pulse_90deg, delay_nosig, pulse_180deg, rx_delay, samples_per_echo, delay_sig, echoes_per_scan  in  CNT_W each  timing values in clk_clk cycles / counts
- adc_data  in  ADC_W  free-running ADC sample
- adc_fifo_in_data  out  ADC_W  sample to FIFO
- adc_fifo_in_valid  out  1  sample valid
- adc_fifo_in_ready  in  1  FIFO ready
- tx_gate  out  1  RF transmit enable
- tx_phase  out  1  0 = 90° pulse, 1 = 180° pulse
- rx_en  out  1  receiver/acquisition window
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan end
- overflow  out  1  sticky: sample dropped
- echo_cnt  out  CNT_W  echoes completed in current scan

Behaviour:
- Reset values:
  - state IDLE.
  - tx_gate, tx_phase, rx_en, busy, done, adc_fifo_in_valid, overflow = 0.
  - echo_cnt, adc_fifo_in_data = 0.
- All outputs are registered.
- Start and latching:
  - start=1 in IDLE latches all eight timing inputs into shadow registers.
  - Same edge: clear overflow and echo_cnt, enter INIT.
  - Input changes mid-scan have no effect.
- Timed-state duration: each timed state lasts max(N,1) cycles, N = its latched value. A down-counter loads N-1 on entry; exit when it reaches 0.
- State sequence:
  - IDLE -> INIT(init_delay) -> P90(pulse_90deg) -> DNOSIG(delay_nosig) -> P180(pulse_180deg) -> RXDLY(rx_delay) -> ACQ(samples_per_echo) -> DSIG(delay_sig).
  - DSIG exit: if echo_cnt+1 < echoes_per_scan, go to P180 and increment echo_cnt; else go to DONE and increment echo_cnt.
  - DONE lasts 1 cycle, then IDLE.
- Output decode:
  - tx_gate=1 exactly in P90/P180.
  - tx_phase=1 in P180; tx_phase holds its value outside pulses.
  - rx_en=1 exactly in ACQ.
  - busy=1 in every state except IDLE.
  - done=1 exactly in DONE.
- echoes_per_scan=0: start goes IDLE -> DONE directly; no pulses, no samples; done 1 cycle after start.
- Streaming:
  - Each ACQ cycle registers adc_data into adc_fifo_in_data with valid=1. Latency is 1 cycle, so valid beats lag rx_en by one cycle.
  - The pulse sequence never stalls. If valid=1 and ready=0, the beat is dropped and overflow sets (sticky until next start).
  - Valid is a single-cycle beat; it is never held.
- abort:
  - Next edge: state IDLE; tx_gate, rx_en, valid, busy = 0; no done pulse.
  - echo_cnt and overflow hold their values.
  - abort has priority over start.
- start while busy: ignored.
- Reset mid-scan: all outputs return to reset values immediately (asynchronous).
- Counter arithmetic: unsigned; echo_cnt never wraps within one scan because it is compared against echoes_per_scan.

Optional Feature:
- Macro: CPMG_PHASE_CYCLE_EN
- Enabled:
  - Adds output tx_phase90_inv (1 bit, reset 0), held constant through a scan.
  - Toggles on each DONE, giving the 90° pulse alternating 0°/180° phase on successive scans for phase cycling.
  - abort does not toggle it.
- Disabled: port absent, no toggle register.

Test Plan:
- Nominal scan: init=2, p90=4, dnosig=10, p180=8, rxdly=3, spe=5, dsig=6, echoes=2, ready=1, start at cycle 0.
  - tx_gate high cycles 3-6 (phase 0), 17-24 and 39-46 (phase 1).
  - rx_en high cycles 28-32 and 50-54; 10 valid beats, each one cycle after rx_en.
  - done=1 at cycle 61; echo_cnt=2; overflow=0.
- Backpressure: same config, ready=0 during cycle 30 -> that beat dropped, 9 beats accepted, overflow=1 after done. Next start clears overflow to 0.
- Zero values: init=0, dnosig=0, echoes=1, others as nominal -> each zero state lasts 1 cycle. echoes=0 -> done 1 cycle after start, no tx_gate, no valid.
- Abort: abort asserted during the second P180 -> next cycle tx_gate=0, busy=0, state IDLE, no done; echo_cnt=1. A new start then runs a full scan.
- Reset and start-while-busy: start pulsed mid-scan is ignored (timing unchanged). reset_reset_n low during ACQ -> rx_en, valid, busy = 0 asynchronously.
- With CPMG_PHASE_CYCLE_EN: three back-to-back scans -> tx_phase90_inv = 0, 1, 0 during each P90.

Source files
------------

// File: rtl/cpmg_seq_ctrl.sv
// CPMG NMR scan sequencer: timed pulse/acquire FSM, TX/RX gating, ADC FIFO feed.
// Optional CPMG_PHASE_CYCLE_EN adds tx_phase90_inv toggling per completed scan.
module cpmg_seq_ctrl #(
  parameter int CNT_W = 32,
  parameter int ADC_W = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] init_delay,
  input  logic [CNT_W-1:0] pulse_90deg,
  input  logic [CNT_W-1:0] delay_nosig,
  input  logic [CNT_W-1:0] pulse_180deg,
  input  logic [CNT_W-1:0] rx_delay,
  input  logic [CNT_W-1:0] samples_per_echo,
  input  logic [CNT_W-1:0] delay_sig,
  input  logic [CNT_W-1:0] echoes_per_scan,
  input  logic [ADC_W-1:0] adc_data,
  output logic [ADC_W-1:0] adc_fifo_in_data,
  output logic             adc_fifo_in_valid,
  input  logic             adc_fifo_in_ready,
  output logic             tx_gate,
  output logic             tx_phase,
  output logic             rx_en,
  output logic             busy,
  output logic             done,
  output logic             overflow,
`ifdef CPMG_PHASE_CYCLE_EN
  output logic             tx_phase90_inv,
`endif
  output logic [CNT_W-1:0] echo_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_P90, S_DNOSIG, S_P180,
    S_RXDLY, S_ACQ, S_DSIG, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] echo_q, echo_d;
  logic [CNT_W-1:0] p90_q, dnosig_q, p180_q;
  logic [CNT_W-1:0] rxdly_q, spe_q, dsig_q, eps_q;

  logic             gate_q, gate_d;
  logic             phase_q, phase_d;
  logic             rx_q, rx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [ADC_W-1:0] data_q, data_d;

  logic start_acc;
  logic cnt_zero;

  // Down-counter preload so a state lasts max(N,1) cycles
  function automatic logic [CNT_W-1:0] ld(input logic [CNT_W-1:0] n);
    return (n == '0) ? '0 : n - CNT_W'(1);
  endfunction

  assign start_acc = (state_q == S_IDLE) && start && !abort;
  assign cnt_zero  = (cnt_q == '0);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      echo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      echo_q  <= echo_d;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      p90_q    <= '0;
      dnosig_q <= '0;
      p180_q   <= '0;
      rxdly_q  <= '0;
      spe_q    <= '0;
      dsig_q   <= '0;
      eps_q    <= '0;
    end else if (start_acc) begin
      p90_q    <= pulse_90deg;
      dnosig_q <= delay_nosig;
      p180_q   <= pulse_180deg;
      rxdly_q  <= rx_delay;
      spe_q    <= samples_per_echo;
      dsig_q   <= delay_sig;
      eps_q    <= echoes_per_scan;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
    echo_d  = echo_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = cnt_q;
        if (start) begin
          echo_d = '0;
          if (echoes_per_scan == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_INIT;
            cnt_d   = ld(init_delay);
          end
        end
      end
      S_INIT: if (cnt_zero) begin
        state_d = S_P90;
        cnt_d   = ld(p90_q);
      end
      S_P90: if (cnt_zero) begin
        state_d = S_DNOSIG;
        cnt_d   = ld(dnosig_q);
      end
      S_DNOSIG: if (cnt_zero) begin
        state_d = S_P180;
        cnt_d   = ld(p180_q);
      end
      S_P180: if (cnt_zero) begin
        state_d = S_RXDLY;
        cnt_d   = ld(rxdly_q);
      end
      S_RXDLY: if (cnt_zero) begin
        state_d = S_ACQ;
        cnt_d   = ld(spe_q);
      end
      S_ACQ: if (cnt_zero) begin
        state_d = S_DSIG;
        cnt_d   = ld(dsig_q);
      end
      S_DSIG: if (cnt_zero) begin
        echo_d = echo_q + CNT_W'(1);
        if ((echo_q + CNT_W'(1)) < eps_q) begin
          state_d = S_P180;
          cnt_d   = ld(p180_q);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = cnt_q;
      echo_d  = echo_q;
    end
  end

  // Outputs are decoded from the next state so they align with the state
  always_comb begin
    gate_d  = (state_d == S_P90) || (state_d == S_P180);
    phase_d = phase_q;
    if (state_d == S_P90)  phase_d = 1'b0;
    if (state_d == S_P180) phase_d = 1'b1;
    rx_d    = (state_d == S_ACQ);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    valid_d = (state_q == S_ACQ) && !abort;
    data_d  = (state_q == S_ACQ) ? adc_data : data_q;
    ovf_d   = ovf_q | (valid_q & ~adc_fifo_in_ready);
    if (start_acc) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      gate_q  <= 1'b0;
      phase_q <= 1'b0;
      rx_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      gate_q  <= gate_d;
      phase_q <= phase_d;
      rx_q    <= rx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
    end
  end

`ifdef CPMG_PHASE_CYCLE_EN
  logic inv_q, inv_d;

  // Flip after DONE so the value stays fixed for the whole scan
  always_comb begin
    inv_d = inv_q;
    if ((state_q == S_DONE) && !abort) inv_d = ~inv_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) inv_q <= 1'b0;
    else                inv_q <= inv_d;
  end

  assign tx_phase90_inv = inv_q;
`endif

  assign tx_gate           = gate_q;
  assign tx_phase          = phase_q;
  assign rx_en             = rx_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign adc_fifo_in_valid = valid_q;
  assign adc_fifo_in_data  = data_q;
  assign overflow          = ovf_q;
  assign echo_cnt          = echo_q;

endmodule

// File: tb/tb_cpmg_seq_ctrl.sv
// Directed bench for cpmg_seq_ctrl: nominal, backpressure, zero values,
// abort, start-while-busy, async reset and optional phase cycling.
module tb_cpmg_seq_ctrl;
  localparam int CW = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] init_delay = '0, pulse_90deg = '0, delay_nosig = '0;
  logic [CW-1:0] pulse_180deg = '0, rx_delay = '0, samples_per_echo = '0;
  logic [CW-1:0] delay_sig = '0, echoes_per_scan = '0;
  logic [AW-1:0] adc = '0;
  logic          ready = 1'b1;
  logic [AW-1:0] fdata;
  logic          fvalid, tx_gate, tx_phase, rx_en, busy, done, overflow;
  logic [CW-1:0] echo_cnt;
`ifdef CPMG_PHASE_CYCLE_EN
  logic          inv;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cpmg_seq_ctrl #(.CNT_W(CW), .ADC_W(AW)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .abort(abort),
    .init_delay(init_delay), .pulse_90deg(pulse_90deg),
    .delay_nosig(delay_nosig), .pulse_180deg(pulse_180deg),
    .rx_delay(rx_delay), .samples_per_echo(samples_per_echo),
    .delay_sig(delay_sig), .echoes_per_scan(echoes_per_scan),
    .adc_data(adc), .adc_fifo_in_data(fdata),
    .adc_fifo_in_valid(fvalid), .adc_fifo_in_ready(ready),
    .tx_gate(tx_gate), .tx_phase(tx_phase), .rx_en(rx_en),
    .busy(busy), .done(done), .overflow(overflow),
`ifdef CPMG_PHASE_CYCLE_EN
    .tx_phase90_inv(inv),
`endif
    .echo_cnt(echo_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    adc = AW'(32'h100 + cyc);
  endtask

  task automatic kick();
    start = 1'b1;
    cyc   = 0;
    adc   = 16'h100;
    step();
    start = 1'b0;
  endtask

  task automatic cfg_nominal();
    init_delay = 2; pulse_90deg = 4; delay_nosig = 10;
    pulse_180deg = 8; rx_delay = 3; samples_per_echo = 5;
    delay_sig = 6; echoes_per_scan = 2;
  endtask

  function automatic logic nom_gate(int c);
    return (c >= 3 && c <= 6) || (c >= 17 && c <= 24) || (c >= 39 && c <= 46);
  endfunction
  function automatic logic nom_rx(int c);
    return (c >= 28 && c <= 32) || (c >= 50 && c <= 54);
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if ({tx_gate, tx_phase, rx_en, busy, done, fvalid, overflow} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000000",
        {tx_gate, tx_phase, rx_en, busy, done, fvalid, overflow});
    end
    checks++;
    if (echo_cnt !== '0 || fdata !== '0) begin
      errors++;
      $display("FAIL reset_counts echo=%0d data=%h want 0/0", echo_cnt, fdata);
    end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_nominal();
    int beats = 0;
    cfg_nominal();
    ready = 1'b1;
    kick();
    while (cyc <= 62) begin
      checks++;
      if (tx_gate !== nom_gate(cyc)) begin
        errors++;
        $display("FAIL nom_gate c=%0d got %b want %b", cyc, tx_gate, nom_gate(cyc));
      end
      if (nom_gate(cyc)) begin
        checks++;
        if (tx_phase !== (cyc > 6)) begin
          errors++;
          $display("FAIL nom_phase c=%0d got %b want %b", cyc, tx_phase, cyc > 6);
        end
      end
      checks++;
      if (rx_en !== nom_rx(cyc)) begin
        errors++;
        $display("FAIL nom_rx c=%0d got %b want %b", cyc, rx_en, nom_rx(cyc));
      end
      checks++;
      if (fvalid !== nom_rx(cyc - 1)) begin
        errors++;
        $display("FAIL nom_valid c=%0d got %b want %b", cyc, fvalid, nom_rx(cyc - 1));
      end
      if (fvalid && ready) begin
        beats++;
        checks++;
        if (fdata !== AW'(32'h100 + cyc - 1)) begin
          errors++;
          $display("FAIL nom_data c=%0d got %h want %h", cyc, fdata, AW'(32'h100 + cyc - 1));
        end
      end
      checks++;
      if (done !== (cyc == 61) || busy !== (cyc <= 61)) begin
        errors++;
        $display("FAIL nom_done_busy c=%0d got %b%b want %b%b",
          cyc, done, busy, cyc == 61, cyc <= 61);
      end
      if (cyc == 61) begin
        checks++;
        if (echo_cnt !== 2 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL nom_end echo=%0d ovf=%b want 2/0", echo_cnt, overflow);
        end
      end
      step();
    end
    checks++;
    if (beats != 10) begin
      errors++;
      $display("FAIL nom_beats got %0d want 10", beats);
    end
  endtask

  task automatic test_backpressure();
    int beats = 0;
    cfg_nominal();
    kick();
    while (cyc <= 62) begin
      ready = (cyc == 30) ? 1'b0 : 1'b1;
      if (fvalid && ready) beats++;
      if (cyc == 30) begin
        checks++;
        if (overflow !== 1'b0) begin
          errors++;
          $display("FAIL bp_ovf_early got %b want 0", overflow);
        end
      end
      step();
    end
    ready = 1'b1;
    checks++;
    if (beats != 9) begin
      errors++;
      $display("FAIL bp_beats got %0d want 9", beats);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_ovf_sticky got %b want 1", overflow);
    end
    kick();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL bp_ovf_clear got %b want 0", overflow);
    end
    while (cyc <= 62) step();
  endtask

  task automatic test_zero();
    cfg_nominal();
    init_delay = 0; delay_nosig = 0; echoes_per_scan = 1;
    kick();
    while (cyc <= 30) begin
      checks++;
      if (tx_gate !== ((cyc >= 2 && cyc <= 5) || (cyc >= 7 && cyc <= 14))) begin
        errors++;
        $display("FAIL zero_gate c=%0d got %b", cyc, tx_gate);
      end
      checks++;
      if (rx_en !== (cyc >= 18 && cyc <= 22) || done !== (cyc == 29)) begin
        errors++;
        $display("FAIL zero_rx_done c=%0d got %b%b want %b%b", cyc, rx_en, done,
          cyc >= 18 && cyc <= 22, cyc == 29);
      end
      step();
    end
    checks++;
    if (echo_cnt !== 1) begin
      errors++;
      $display("FAIL zero_echo got %0d want 1", echo_cnt);
    end
    echoes_per_scan = 0;
    kick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || tx_gate !== 1'b0) begin
      errors++;
      $display("FAIL e0_done got d=%b b=%b g=%b want 1 1 0", done, busy, tx_gate);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || fvalid !== 1'b0 || echo_cnt !== 0) begin
      errors++;
      $display("FAIL e0_after got d=%b b=%b v=%b e=%0d want 0 0 0 0",
        done, busy, fvalid, echo_cnt);
    end
    step();
  endtask

  task automatic test_abort();
    cfg_nominal();
    kick();
    while (cyc < 40) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({tx_gate, busy, rx_en, fvalid, done} !== 5'b0 || echo_cnt !== 1) begin
      errors++;
      $display("FAIL abort_out got g%b b%b r%b v%b d%b e=%0d want 0s e=1",
        tx_gate, busy, rx_en, fvalid, done, echo_cnt);
    end
    repeat (25) begin
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle c=%0d got d=%b b=%b want 0 0", cyc, done, busy);
      end
    end
    kick();
    while (cyc < 61) step();
    checks++;
    if (done !== 1'b1 || echo_cnt !== 2) begin
      errors++;
      $display("FAIL abort_rerun got d=%b e=%0d want 1 2", done, echo_cnt);
    end
    step();
  endtask

  task automatic test_start_busy();
    cfg_nominal();
    kick();
    while (cyc <= 62) begin
      start = (cyc == 10);
      if (cyc == 16 || cyc == 17) begin
        checks++;
        if (tx_gate !== (cyc == 17)) begin
          errors++;
          $display("FAIL sb_gate c=%0d got %b want %b", cyc, tx_gate, cyc == 17);
        end
      end
      if (cyc == 61) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL sb_done got %b want 1", done);
        end
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_async_reset();
    cfg_nominal();
    kick();
    while (cyc < 30) step();
    checks++;
    if (rx_en !== 1'b1 || fvalid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre got r=%b v=%b b=%b want 1 1 1", rx_en, fvalid, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rx_en !== 1'b0 || fvalid !== 1'b0 || busy !== 1'b0 || echo_cnt !== 0) begin
      errors++;
      $display("FAIL ar_post got r=%b v=%b b=%b e=%0d want 0 0 0 0",
        rx_en, fvalid, busy, echo_cnt);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

`ifdef CPMG_PHASE_CYCLE_EN
  task automatic test_phase_cycle();
    init_delay = 1; pulse_90deg = 2; delay_nosig = 1; pulse_180deg = 1;
    rx_delay = 1; samples_per_echo = 1; delay_sig = 1; echoes_per_scan = 1;
    for (int s = 0; s < 3; s++) begin
      kick();
      step();
      checks++;
      if (tx_gate !== 1'b1 || inv !== s[0]) begin
        errors++;
        $display("FAIL pc_scan%0d got g=%b inv=%b want 1 %b", s, tx_gate, inv, s[0]);
      end
      while (cyc < 10) step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_zero();
    test_abort();
    test_start_busy();
    test_async_reset();
`ifdef CPMG_PHASE_CYCLE_EN
    test_phase_cycle();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
